iterative_comparator: RTL and testbench
=======================================

// Module: iterative_comparator
// PURPOSE
//   Parametrised, multi-cycle branch comparator. Evaluates EQ/NE/LT/GE/LTU/GEU over
//   WIDTH-bit operands CHUNK bits per cycle, MSB chunk first, stopping at the first
//   differing chunk. Sits between decode and the branch unit in area-reduced cores.
//   Uses valid/ready handshakes on both sides and has a kill input for flushes.
// PARAMETERS
//   WIDTH   32  operand width in bits
//   CHUNK   8   bits compared per cycle; must divide WIDTH; NCHUNK = WIDTH/CHUNK
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous reset, active-low
//   in_valid   in   1      request valid
//   in_ready   out  1      high only in IDLE and when kill is low
//   operation  in   3      funct3: [2:1] 00=eq, 10=lt signed, 11=lt unsigned, 01=illegal; [0] inverts result
//   operand1   in   WIDTH  left operand
//   operand2   in   WIDTH  right operand
//   kill       in   1      synchronous abort of any in-flight request
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   result     out  1      comparison outcome, XORed with operation[0]
//   illegal    out  1      operation[2:1]==01 for this result
// BEHAVIOUR
//   - Reset (rst_n low, async): state=IDLE, out_valid=0, result=0, illegal=0, index=0.
//   - States: IDLE, SCAN, DONE.
//   - IDLE: accept when in_valid & in_ready. Latch operands, operation, index=NCHUNK-1.
//     Next state is SCAN. Illegal op instead goes directly to DONE with result=0,
//     illegal=1; no inversion is applied.
//   - SCAN: compare chunk[index] of both operands.
//     - Chunks differ: decide and go to DONE.
//       - eq: 0.
//       - ltu: unsigned chunk compare.
//       - lt: on the top chunk (index==NCHUNK-1), flip the chunk MSBs before an unsigned
//         compare; on lower chunks use unsigned compare.
//     - Chunks equal and index==0: eq=1, lt=0; go to DONE.
//     - Otherwise: index decrements and the state stays SCAN.
//   - DONE: out_valid=1. result and illegal stay stable until out_ready.
//     - On out_valid & out_ready, go to IDLE. No new request is accepted in that cycle.
//   - Latency from accept cycle T:
//     - Decision at chunk index i: out_valid rises at T + (NCHUNK - i) + 1.
//     - Worst case: T + NCHUNK + 1. Illegal op: T + 1.
//   - Throughput: one request in flight. in_ready is 0 in SCAN and DONE.
//   - kill (any state): next state is IDLE and out_valid goes 0 next cycle.
//     - kill suppresses acceptance in the same cycle, because in_ready is low.
//     - kill with out_ready in DONE: the result is dropped and the consumer must ignore it.
//   - NCHUNK==1 (CHUNK==WIDTH): always decides in one SCAN cycle.
//   - Inputs are sampled only at accept. Later changes to operand1/operand2/operation
//     have no effect on the request in flight.
// TESTING
//   1. W=32,C=8: beq, op1=op2=0x12345678 -> result=1, out_valid 5 cycles after accept.
//   2. blt, op1=0x80000000, op2=0x00000001 -> result=1 (signed), decided at top chunk,
//      out_valid 2 cycles after accept. Same operands with bltu -> result=0.
//   3. bge, op1=0x00000105, op2=0x00000106 -> result=0, decided at chunk 0.
//      bne with same operands -> result=1.
//   4. operation=3'b010 -> illegal=1, result=0, out_valid 1 cycle after accept.
//   5. Backpressure: hold out_ready=0 for 3 cycles in DONE -> result stable,
//      in_ready=0 throughout. Assert kill mid-SCAN -> out_valid never rises,
//      in_ready=1 the next cycle.
//   6. Assert rst_n low mid-SCAN -> out_valid=0, in_ready=1 immediately.
//      Then run a random-vector sweep against a reference model for C in {1,8,32}.

Source files
------------

// File: rtl/iterative_comparator.sv
// -----------------------------------------------------------------------------
// iterative_comparator
//
// Multi-cycle branch comparator. Evaluates EQ/NE/LT/GE/LTU/GEU on two WIDTH-bit
// operands, CHUNK bits per cycle, starting at the most significant chunk and
// stopping at the first chunk where the operands differ.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request valid
//   in_ready   request accepted when in_valid & in_ready (IDLE and no kill)
//   operation  funct3: [2:1] 00=eq, 10=lt signed, 11=lt unsigned, 01=illegal;
//              [0] inverts the result of a legal operation
//   operand1   left operand
//   operand2   right operand
//   kill       synchronous abort of whatever is in flight
//   out_valid  result valid (held until out_ready)
//   out_ready  consumer accepts the result
//   result     comparison outcome (already XORed with operation[0])
//   illegal    the accepted operation was the reserved encoding
//   dbg_state  current FSM state (0=IDLE, 1=SCAN, 2=DONE)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Once raised, out_valid and its payload (result, illegal) stay
// stable until that transfer or a kill; ready never depends on the other
// side's valid in the same direction.
// -----------------------------------------------------------------------------
module iterative_comparator #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       operation,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             result,
    output logic             illegal,
    output logic [1:0]       dbg_state
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [IW-1:0]    TOP_INDEX = IW'(NCHUNK - 1);
    // Sign bit position within a chunk; only meaningful on the top chunk.
    localparam logic [CHUNK-1:0] CHUNK_MSB = CHUNK'(1) << (CHUNK - 1);

    localparam logic [1:0] KIND_EQ  = 2'b00;
    localparam logic [1:0] KIND_ILL = 2'b01;
    localparam logic [1:0] KIND_LT  = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // Latched request. The operand registers shift left by one chunk per
    // SCAN step, so the chunk under test always sits in the top CHUNK bits
    // and no variable-index mux is needed.
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       kind_q;
    logic             inv_q;
    logic [IW-1:0]    index_q;
    logic             result_q;
    logic             illegal_q;

    logic             accept;
    logic             op_illegal;
    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK-1:0] flip;
    logic             at_top;
    logic             at_last;
    logic             differ;
    logic             chunk_lt;
    logic             decide;
    logic             raw_result;

    // -------------------------------------------------------------------------
    // Datapath decode
    // -------------------------------------------------------------------------
    always_comb begin
        accept     = in_valid && in_ready;
        op_illegal = (operation[2:1] == KIND_ILL);

        chunk_a = a_q[WIDTH-1 -: CHUNK];
        chunk_b = b_q[WIDTH-1 -: CHUNK];

        at_top  = (index_q == TOP_INDEX);
        at_last = (index_q == '0);

        // A signed compare only differs from an unsigned one in the sign bit,
        // which lives in the top chunk; inverting both MSBs there turns the
        // signed order into an unsigned one.
        flip     = ((kind_q == KIND_LT) && at_top) ? CHUNK_MSB : '0;
        chunk_lt = (chunk_a ^ flip) < (chunk_b ^ flip);
        differ   = (chunk_a != chunk_b);
        decide   = differ || at_last;

        // Equal all the way down: eq is true, lt/ltu are false.
        if (differ) begin
            raw_result = (kind_q == KIND_EQ) ? 1'b0 : chunk_lt;
        end else begin
            raw_result = (kind_q == KIND_EQ);
        end
    end

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = op_illegal ? DONE : SCAN;
                end
            end
            SCAN: begin
                if (decide) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A flush wins over everything, including a result being consumed.
        if (kill) begin
            state_d = IDLE;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        in_ready  = (state_q == IDLE) && !kill;
        out_valid = (state_q == DONE);
        dbg_state = state_q;
        result    = result_q;
        illegal   = illegal_q;
    end

    // -------------------------------------------------------------------------
    // Request / result registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            kind_q    <= KIND_EQ;
            inv_q     <= 1'b0;
            index_q   <= '0;
            result_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            if (state_q == IDLE) begin
                if (accept) begin
                    a_q       <= operand1;
                    b_q       <= operand2;
                    kind_q    <= operation[2:1];
                    inv_q     <= operation[0];
                    index_q   <= TOP_INDEX;
                    result_q  <= 1'b0;
                    // The reserved encoding reports 0 without inversion.
                    illegal_q <= op_illegal;
                end
            end else if (state_q == SCAN) begin
                if (decide) begin
                    result_q <= raw_result ^ inv_q;
                end else begin
                    index_q <= index_q - 1'b1;
                    a_q     <= a_q << CHUNK;
                    b_q     <= b_q << CHUNK;
                end
            end
        end
    end

endmodule

// File: tb/tb_iterative_comparator.sv
// -----------------------------------------------------------------------------
// tb_iterative_comparator
//
// Drives three comparators (CHUNK = 1, 8, 32 over WIDTH = 32) from one shared
// stimulus stream and checks result, illegal flag and latency of each against
// a behavioural model that works on whole operands.
// -----------------------------------------------------------------------------
module tb_iterative_comparator;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        kill;
    logic        out_ready;
    logic [2:0]  operation;
    logic [31:0] operand1;
    logic [31:0] operand2;

    wire  [2:0]  ir;
    wire  [2:0]  ov;
    wire  [2:0]  res;
    wire  [2:0]  ill;
    wire  [1:0]  dbg0;
    wire  [1:0]  dbg1;
    wire  [1:0]  dbg2;

    int tests  = 0;
    int failed = 0;

    logic cap_r   [3];
    logic cap_i   [3];
    int   cap_lat [3];

    always #5 clk = ~clk;

    iterative_comparator #(.WIDTH(32), .CHUNK(1)) u_c1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]),
        .operation(operation), .operand1(operand1), .operand2(operand2),
        .kill(kill), .out_valid(ov[0]), .out_ready(out_ready),
        .result(res[0]), .illegal(ill[0]), .dbg_state(dbg0)
    );

    iterative_comparator #(.WIDTH(32), .CHUNK(8)) u_c8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]),
        .operation(operation), .operand1(operand1), .operand2(operand2),
        .kill(kill), .out_valid(ov[1]), .out_ready(out_ready),
        .result(res[1]), .illegal(ill[1]), .dbg_state(dbg1)
    );

    iterative_comparator #(.WIDTH(32), .CHUNK(32)) u_c32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]),
        .operation(operation), .operand1(operand1), .operand2(operand2),
        .kill(kill), .out_valid(ov[2]), .out_ready(out_ready),
        .result(res[2]), .illegal(ill[2]), .dbg_state(dbg2)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Scoreboard helpers
    // -------------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int chunk_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 8 : 32);
    endfunction

    // Whole-operand reference: result from plain arithmetic, latency from the
    // position of the most significant differing chunk.
    function automatic void model(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, input int c,
                                  output logic r, output logic il, output int lat);
        int          nch;
        int          hi;
        logic [31:0] x;
        nch = 32 / c;
        if (op[2:1] == 2'b01) begin
            r   = 1'b0;
            il  = 1'b1;
            lat = 1;
            return;
        end
        il = 1'b0;
        case (op[2:1])
            2'b00:   r = (a == b);
            2'b10:   r = ($signed(a) < $signed(b));
            default: r = (a < b);
        endcase
        r  = r ^ op[0];
        x  = a ^ b;
        hi = 0;
        for (int i = 0; i < nch; i++) begin
            if ((x >> (i * c)) != 32'd0) hi = i;
        end
        lat = nch - hi + 1;
    endfunction

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble();
        operation = 3'($urandom_range(0, 7));
        operand1  = $urandom;
        operand2  = $urandom;
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while (ir !== 3'b111 && w < 60) begin
            tick();
            w++;
        end
        check("in_ready_idle", {29'd0, ir}, 32'd7);
    endtask

    // Issue one request with out_ready high; record first out_valid of each
    // instance (latency counted in edges from the accept edge).
    task automatic run_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int         n;
        logic [2:0] seen;
        wait_idle();
        out_ready = 1'b1;
        operation = op;
        operand1  = a;
        operand2  = b;
        in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cap_lat[k] = 0;
            cap_r[k]   = 1'b0;
            cap_i[k]   = 1'b0;
        end
        tick();
        in_valid = 1'b0;
        scramble();
        n    = 1;
        seen = 3'b000;
        while (seen != 3'b111 && n <= 40) begin
            for (int k = 0; k < 3; k++) begin
                if (!seen[k] && ov[k] === 1'b1) begin
                    seen[k]    = 1'b1;
                    cap_lat[k] = n;
                    cap_r[k]   = res[k];
                    cap_i[k]   = ill[k];
                end
            end
            if (seen != 3'b111) begin
                tick();
                n++;
            end
        end
    endtask

    task automatic check_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic r;
        logic il;
        int   lat;
        for (int k = 0; k < 3; k++) begin
            model(op, a, b, chunk_of(k), r, il, lat);
            check($sformatf("result c%0d op%0d %h/%h", chunk_of(k), op, a, b), {31'd0, cap_r[k]}, {31'd0, r});
            check($sformatf("illegal c%0d op%0d", chunk_of(k), op), {31'd0, cap_i[k]}, {31'd0, il});
            check($sformatf("latency c%0d op%0d %h/%h", chunk_of(k), op, a, b), cap_lat[k], lat);
        end
    endtask

    // -------------------------------------------------------------------------
    // Directed steps, then random sweep
    // -------------------------------------------------------------------------
    initial begin
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        rose;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        kill      = 1'b0;
        out_ready = 1'b1;
        operation = 3'b000;
        operand1  = 32'd0;
        operand2  = 32'd0;
        repeat (3) tick();

        check("reset_out_valid", {29'd0, ov}, 32'd0);
        check("reset_in_ready", {29'd0, ir}, 32'd7);
        check("reset_result", {29'd0, res}, 32'd0);
        check("reset_illegal", {29'd0, ill}, 32'd0);
        check("reset_state", {30'd0, dbg1}, 32'd0);
        rst_n = 1'b1;
        tick();

        // beq on equal operands: full scan
        run_req(3'b000, 32'h12345678, 32'h12345678);
        check("beq_result", {31'd0, cap_r[1]}, 32'd1);
        check("beq_latency", cap_lat[1], 32'd5);
        check_model(3'b000, 32'h12345678, 32'h12345678);

        // blt / bltu decided on the top chunk
        run_req(3'b100, 32'h80000000, 32'h00000001);
        check("blt_result", {31'd0, cap_r[1]}, 32'd1);
        check("blt_latency", cap_lat[1], 32'd2);
        check_model(3'b100, 32'h80000000, 32'h00000001);
        run_req(3'b110, 32'h80000000, 32'h00000001);
        check("bltu_result", {31'd0, cap_r[1]}, 32'd0);
        check_model(3'b110, 32'h80000000, 32'h00000001);

        // bge / bne decided on chunk 0
        run_req(3'b101, 32'h00000105, 32'h00000106);
        check("bge_result", {31'd0, cap_r[1]}, 32'd0);
        check("bge_latency", cap_lat[1], 32'd5);
        check_model(3'b101, 32'h00000105, 32'h00000106);
        run_req(3'b001, 32'h00000105, 32'h00000106);
        check("bne_result", {31'd0, cap_r[1]}, 32'd1);
        check_model(3'b001, 32'h00000105, 32'h00000106);

        // illegal operation
        run_req(3'b010, 32'h00000001, 32'h00000001);
        check("illegal_flag", {31'd0, cap_i[1]}, 32'd1);
        check("illegal_result", {31'd0, cap_r[1]}, 32'd0);
        check("illegal_latency", cap_lat[1], 32'd1);
        check_model(3'b011, 32'h00000007, 32'h00000003);

        // Backpressure in DONE
        wait_idle();
        out_ready = 1'b0;
        operation = 3'b100;
        operand1  = 32'h80000000;
        operand2  = 32'h00000001;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        scramble();
        tick();
        check("bp_valid", {29'd0, ov}, 32'd7);
        check("bp_result", {29'd0, res}, 32'd7);
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("bp_hold_valid_%0d", i), {31'd0, ov[1]}, 32'd1);
            check($sformatf("bp_hold_result_%0d", i), {31'd0, res[1]}, 32'd1);
            check($sformatf("bp_in_ready_%0d", i), {31'd0, ir[1]}, 32'd0);
        end
        out_ready = 1'b1;
        tick();
        check("bp_release_valid", {31'd0, ov[1]}, 32'd0);
        check("bp_release_ready", {31'd0, ir[1]}, 32'd1);

        // Kill mid-SCAN
        wait_idle();
        operation = 3'b000;
        operand1  = 32'hCAFEF00D;
        operand2  = 32'hCAFEF00D;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        check("kill_pre_state", {30'd0, dbg1}, 32'd1);
        kill = 1'b1;
        #1;
        check("kill_in_ready_low", {29'd0, ir}, 32'd0);
        tick();
        kill = 1'b0;
        #1;
        check("kill_in_ready_next", {31'd0, ir[1]}, 32'd1);
        check("kill_state", {30'd0, dbg1}, 32'd0);
        rose = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (ov[1] === 1'b1) rose = 1'b1;
            tick();
        end
        check("kill_no_valid", {31'd0, rose}, 32'd0);

        // kill blocks an accept in the same cycle
        wait_idle();
        operation = 3'b010;
        in_valid  = 1'b1;
        kill      = 1'b1;
        #1;
        check("kill_blocks_ready", {31'd0, ir[1]}, 32'd0);
        tick();
        in_valid = 1'b0;
        kill     = 1'b0;
        #1;
        check("kill_blocks_accept_valid", {29'd0, ov}, 32'd0);
        check("kill_blocks_accept_state", {30'd0, dbg1}, 32'd0);

        // Asynchronous reset mid-SCAN
        wait_idle();
        operation = 3'b000;
        operand1  = 32'h0F0F0F0F;
        operand2  = 32'h0F0F0F0F;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", {29'd0, ov}, 32'd0);
        check("rst_mid_ready", {31'd0, ir[1]}, 32'd1);
        check("rst_mid_state", {30'd0, dbg1}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Random sweep
        for (int it = 0; it < 160; it++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 3))
                0:       b = $urandom;
                1:       b = a;
                2:       b = a ^ (32'd1 << $urandom_range(0, 31));
                default: b = a ^ 32'($urandom_range(1, 255));
            endcase
            run_req(op, a, b);
            check_model(op, a, b);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
